// File: rtl/ttc_resync_ctrl_if.sv
// rtl/ttc_resync_ctrl_if.sv - request/status bundle between the resync controller and its environment
interface ttc_resync_ctrl_if #(
    parameter int MXBXN    = 12,
    parameter int CNT_BITS = 16
);
    logic                ext_resync;
    logic                sw_resync;
    logic                auto_resync_en;
    logic [MXBXN-1:0]    bxn_offset_cfg;
    logic                bx0_local;
    logic                bx0_sync_err;
    logic                bxn_sync_err;
    logic                cnt_reset;
    logic                ttc_resync;
    logic [MXBXN-1:0]    bxn_offset;
    logic                locked;
    logic                busy;
    logic                timeout_err;
    logic [CNT_BITS-1:0] bx0_err_cnt;
    logic [CNT_BITS-1:0] bxn_err_cnt;
    logic [CNT_BITS-1:0] resync_cnt;
    logic [CNT_BITS-1:0] auto_resync_cnt;

    modport master (
        output ext_resync, sw_resync, auto_resync_en, bxn_offset_cfg,
               bx0_local, bx0_sync_err, bxn_sync_err, cnt_reset,
        input  ttc_resync, bxn_offset, locked, busy, timeout_err,
               bx0_err_cnt, bxn_err_cnt, resync_cnt, auto_resync_cnt
    );

    modport slave (
        input  ext_resync, sw_resync, auto_resync_en, bxn_offset_cfg,
               bx0_local, bx0_sync_err, bxn_sync_err, cnt_reset,
        output ttc_resync, bxn_offset, locked, busy, timeout_err,
               bx0_err_cnt, bxn_err_cnt, resync_cnt, auto_resync_cnt
    );
endinterface

// File: rtl/ttc_resync_ctrl.sv
// rtl/ttc_resync_ctrl.sv - TTC bunch-counter resync sequencer with statistics (optional macro TTC_AUTO_RESYNC_EN)
module ttc_resync_ctrl #(
    parameter int MXBXN          = 12,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int AUTO_THRESH    = 4,
    parameter int CNT_BITS       = 16
) (
    input  logic             clock,
    input  logic             reset,
    ttc_resync_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HOLDOFF, S_WAIT_BX0, S_LOCKED} state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES);

    state_t              state_q, state_d;
    logic [7:0]          hold_q, hold_d;
    logic [MXBXN-1:0]    tmo_q, tmo_d;
    logic                pend_q, pend_d;
    logic                ttc_q;
    logic [MXBXN-1:0]    offset_q;
    logic                timeout_q;
    logic [CNT_BITS-1:0] bx0_cnt_q, bxn_cnt_q, rsy_cnt_q, auto_cnt_q;
    logic                tmo_hit;
    logic                auto_req;
    logic                auto_win;
    logic                in_busy;

    assign in_busy = (state_q == S_ISSUE) || (state_q == S_HOLDOFF) || (state_q == S_WAIT_BX0);

`ifdef TTC_AUTO_RESYNC_EN
    localparam logic [3:0] THRESH = 4'(AUTO_THRESH);
    logic [3:0] consec_q, consec_next;

    // Run of consecutive error cycles in LOCKED, including the current cycle
    always_comb begin
        consec_next = 4'd0;
        if (state_q == S_LOCKED && (bus.bx0_sync_err || bus.bxn_sync_err))
            consec_next = (consec_q >= THRESH) ? THRESH : consec_q + 4'd1;
    end

    assign auto_req = (state_q == S_LOCKED) && bus.auto_resync_en && (consec_next == THRESH);

    // Run counter only lives in LOCKED; leaving (including via ISSUE) clears it
    always_ff @(posedge clock) begin
        if (reset || state_d != S_LOCKED) consec_q <= 4'd0;
        else                              consec_q <= consec_next;
    end
`else
    logic unused_auto_en;
    assign unused_auto_en = bus.auto_resync_en;
    assign auto_req       = 1'b0;
`endif

    // Auto only wins when no ext, sw or pending sw request competes
    assign auto_win = auto_req && !bus.ext_resync && !bus.sw_resync && !pend_q;

    // Next-state, holdoff/timeout counters and pending sw bit
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        tmo_hit = 1'b0;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ext_resync || bus.sw_resync) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_HOLDOFF;
                hold_d  = HOLD_LOAD;
            end
            S_HOLDOFF: begin
                if (hold_q <= 8'd1) begin
                    state_d = S_WAIT_BX0;
                    tmo_d   = '0;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
                if (bus.ext_resync) state_d = S_ISSUE;
            end
            S_WAIT_BX0: begin
                if (bus.ext_resync) begin
                    state_d = S_ISSUE;
                end else if (bus.bx0_local) begin
                    state_d = S_LOCKED;
                end else if (&tmo_q) begin
                    state_d = S_ISSUE;
                    tmo_hit = 1'b1;
                end else begin
                    tmo_d = tmo_q + MXBXN'(1);
                end
            end
            S_LOCKED: begin
                if (bus.ext_resync || bus.sw_resync || pend_q || auto_req) state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
        // Any resync leaving IDLE/LOCKED services the pending strobe
        if ((state_q == S_IDLE || state_q == S_LOCKED) && state_d == S_ISSUE) pend_d = 1'b0;
        if (in_busy && bus.sw_resync) pend_d = 1'b1;
    end

    // State, registered resync pulse, offset latch and saturating statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_q     <= 8'd0;
            tmo_q      <= '0;
            pend_q     <= 1'b0;
            ttc_q      <= 1'b0;
            offset_q   <= '0;
            timeout_q  <= 1'b0;
            bx0_cnt_q  <= '0;
            bxn_cnt_q  <= '0;
            rsy_cnt_q  <= '0;
            auto_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
            pend_q  <= pend_d;
            ttc_q   <= (state_d == S_ISSUE);
            if (state_d == S_ISSUE) offset_q <= bus.bxn_offset_cfg;
            if (bus.cnt_reset) begin
                timeout_q  <= 1'b0;
                bx0_cnt_q  <= '0;
                bxn_cnt_q  <= '0;
                rsy_cnt_q  <= '0;
                auto_cnt_q <= '0;
            end else begin
                if (tmo_hit) timeout_q <= 1'b1;
                if (state_d == S_ISSUE && !(&rsy_cnt_q)) rsy_cnt_q <= rsy_cnt_q + CNT_BITS'(1);
                if (state_d == S_ISSUE && auto_win && !(&auto_cnt_q))
                    auto_cnt_q <= auto_cnt_q + CNT_BITS'(1);
                if (state_q == S_LOCKED && bus.bx0_sync_err && !(&bx0_cnt_q))
                    bx0_cnt_q <= bx0_cnt_q + CNT_BITS'(1);
                if (state_q == S_LOCKED && bus.bxn_sync_err && !(&bxn_cnt_q))
                    bxn_cnt_q <= bxn_cnt_q + CNT_BITS'(1);
            end
        end
    end

    assign bus.ttc_resync      = ttc_q;
    assign bus.bxn_offset      = offset_q;
    assign bus.locked          = (state_q == S_LOCKED);
    assign bus.busy            = in_busy;
    assign bus.timeout_err     = timeout_q;
    assign bus.bx0_err_cnt     = bx0_cnt_q;
    assign bus.bxn_err_cnt     = bxn_cnt_q;
    assign bus.resync_cnt      = rsy_cnt_q;
    assign bus.auto_resync_cnt = auto_cnt_q;
endmodule

// File: tb/tb_ttc_resync_ctrl.sv
// tb/tb_ttc_resync_ctrl.sv - directed self-checking bench for ttc_resync_ctrl
module tb_ttc_resync_ctrl;
    logic clock = 1'b0;
    logic reset;
    int   nerr = 0;
    int   nchk = 0;
    int   pulses = 0;

    always #5 clock = ~clock;

    ttc_resync_ctrl_if #(.MXBXN(12), .CNT_BITS(16)) bus ();

    ttc_resync_ctrl #(
        .MXBXN(12), .HOLDOFF_CYCLES(16), .AUTO_THRESH(4), .CNT_BITS(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clock);
        #1;
        if (bus.ttc_resync === 1'b1) pulses++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From the ISSUE cycle: 1 step to HOLDOFF, 16 to WAIT_BX0, then a bx0 pulse to lock
    task automatic lock_seq();
        step();
        repeat (16) step();
        bus.bx0_local = 1'b1;
        step();
        bus.bx0_local = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.ext_resync     = 1'b0;
        bus.sw_resync      = 1'b0;
        bus.auto_resync_en = 1'b0;
        bus.bxn_offset_cfg = 12'h000;
        bus.bx0_local      = 1'b0;
        bus.bx0_sync_err   = 1'b0;
        bus.bxn_sync_err   = 1'b0;
        bus.cnt_reset      = 1'b0;
        step();
        step();
        chk("rst_ttc", 32'(bus.ttc_resync), 32'd0);
        chk("rst_offset", 32'(bus.bxn_offset), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_resync_cnt", 32'(bus.resync_cnt), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // 1: sw resync from IDLE, offset latch, holdoff, wait for BX0
        bus.bxn_offset_cfg = 12'h0A5;
        bus.sw_resync = 1'b1;
        step();
        bus.sw_resync = 1'b0;
        bus.bxn_offset_cfg = 12'h3C3;
        chk("t1_ttc_high", 32'(bus.ttc_resync), 32'd1);
        chk("t1_offset", 32'(bus.bxn_offset), 32'h0A5);
        chk("t1_resync_cnt", 32'(bus.resync_cnt), 32'd1);
        step();
        chk("t1_ttc_one_cycle", 32'(bus.ttc_resync), 32'd0);
        chk("t1_offset_held", 32'(bus.bxn_offset), 32'h0A5);
        repeat (15) step();
        chk("t1_busy_holdoff_end", 32'(bus.busy), 32'd1);
        repeat (6) step();
        chk("t1_busy_wait", 32'(bus.busy), 32'd1);
        chk("t1_not_locked", 32'(bus.locked), 32'd0);
        bus.bx0_local = 1'b1;
        step();
        bus.bx0_local = 1'b0;
        chk("t1_locked", 32'(bus.locked), 32'd1);
        chk("t1_busy_low", 32'(bus.busy), 32'd0);
        chk("t1_pulses", 32'(pulses), 32'd1);

        // 2: error statistics in LOCKED and cnt_reset
        bus.bxn_sync_err = 1'b1;
        bus.bx0_sync_err = 1'b1;
        step();
        bus.bx0_sync_err = 1'b0;
        step();
        step();
        bus.bxn_sync_err = 1'b0;
        step();
        chk("t2_bxn_err_cnt", 32'(bus.bxn_err_cnt), 32'd3);
        chk("t2_bx0_err_cnt", 32'(bus.bx0_err_cnt), 32'd1);
        bus.cnt_reset = 1'b1;
        step();
        bus.cnt_reset = 1'b0;
        chk("t2_bxn_cleared", 32'(bus.bxn_err_cnt), 32'd0);
        chk("t2_bx0_cleared", 32'(bus.bx0_err_cnt), 32'd0);
        chk("t2_resync_cleared", 32'(bus.resync_cnt), 32'd0);
        chk("t2_locked_kept", 32'(bus.locked), 32'd1);

        // 3: simultaneous ext+sw from IDLE, then sw strobes during HOLDOFF collapse to one
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.ext_resync = 1'b1;
        bus.sw_resync  = 1'b1;
        step();
        bus.ext_resync = 1'b0;
        bus.sw_resync  = 1'b0;
        chk("t3_ttc", 32'(bus.ttc_resync), 32'd1);
        step();
        chk("t3_single_pulse", 32'(pulses), 32'd2);
        bus.sw_resync = 1'b1;
        step();
        bus.sw_resync = 1'b0;
        step();
        bus.sw_resync = 1'b1;
        step();
        bus.sw_resync = 1'b0;
        chk("t3_still_holdoff", 32'(bus.ttc_resync), 32'd0);
        repeat (20) step();
        bus.bx0_local = 1'b1;
        step();
        bus.bx0_local = 1'b0;
        chk("t3_locked", 32'(bus.locked), 32'd1);
        step();
        chk("t3_pending_ttc", 32'(bus.ttc_resync), 32'd1);
        chk("t3_resync_cnt2", 32'(bus.resync_cnt), 32'd2);
        lock_seq();
        step();
        step();
        chk("t3_collapsed_locked", 32'(bus.locked), 32'd1);
        chk("t3_collapsed_cnt", 32'(bus.resync_cnt), 32'd2);
        chk("t3_pulses", 32'(pulses), 32'd3);

        // 4: BX0 timeout self-retry, ext absorbed in ISSUE, ext restart in HOLDOFF
        bus.ext_resync = 1'b1;
        step();
        bus.ext_resync = 1'b0;
        chk("t4_ext_ttc", 32'(bus.ttc_resync), 32'd1);
        step();
        repeat (16) step();
        repeat (4095) step();
        chk("t4_no_timeout_yet", 32'(bus.timeout_err), 32'd0);
        chk("t4_busy_waiting", 32'(bus.busy), 32'd1);
        step();
        chk("t4_timeout_err", 32'(bus.timeout_err), 32'd1);
        chk("t4_retry_ttc", 32'(bus.ttc_resync), 32'd1);
        chk("t4_resync_cnt", 32'(bus.resync_cnt), 32'd4);
        bus.ext_resync = 1'b1;
        step();
        bus.ext_resync = 1'b0;
        chk("t4_absorbed_ttc", 32'(bus.ttc_resync), 32'd0);
        chk("t4_absorbed_cnt", 32'(bus.resync_cnt), 32'd4);
        bus.ext_resync = 1'b1;
        step();
        bus.ext_resync = 1'b0;
        chk("t4_restart_ttc", 32'(bus.ttc_resync), 32'd1);
        chk("t4_restart_cnt", 32'(bus.resync_cnt), 32'd5);
        chk("t4_pulses", 32'(pulses), 32'd6);

        // 6: reset during HOLDOFF aborts the sequence
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_ttc", 32'(bus.ttc_resync), 32'd0);
        chk("t6_offset", 32'(bus.bxn_offset), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_timeout", 32'(bus.timeout_err), 32'd0);
        chk("t6_resync_cnt", 32'(bus.resync_cnt), 32'd0);
        repeat (20) step();
        chk("t6_no_more_pulses", 32'(pulses), 32'd6);
        chk("t6_idle_locked", 32'(bus.locked), 32'd0);

        // 5: repeated bx0 errors in LOCKED with auto resync enabled
        bus.sw_resync = 1'b1;
        step();
        bus.sw_resync = 1'b0;
        lock_seq();
        chk("t5_locked", 32'(bus.locked), 32'd1);
        bus.auto_resync_en = 1'b1;
        bus.bx0_sync_err = 1'b1;
        repeat (3) step();
        bus.bx0_sync_err = 1'b0;
        step();
        chk("t5_short_run_locked", 32'(bus.locked), 32'd1);
        chk("t5_short_run_pulses", 32'(pulses), 32'd7);
        bus.bx0_sync_err = 1'b1;
        repeat (4) step();
        bus.bx0_sync_err = 1'b0;
        chk("t5_bx0_err_cnt", 32'(bus.bx0_err_cnt), 32'd7);
`ifdef TTC_AUTO_RESYNC_EN
        chk("t5_auto_ttc", 32'(bus.ttc_resync), 32'd1);
        chk("t5_auto_cnt", 32'(bus.auto_resync_cnt), 32'd1);
        chk("t5_resync_cnt", 32'(bus.resync_cnt), 32'd2);
`else
        chk("t5_no_auto_ttc", 32'(bus.ttc_resync), 32'd0);
        chk("t5_auto_cnt_zero", 32'(bus.auto_resync_cnt), 32'd0);
        chk("t5_still_locked", 32'(bus.locked), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
